// File: rtl/rock_sequencer.sv
// Closed-loop rocking sequencer: turns heart-rate samples into 4-bit freq/amp commands.
// Optional watchdog on missing heart-rate samples in TRACK is enabled by defining WATCHDOG_EN.
module rock_sequencer #(
  parameter int F_START   = 8,
  parameter int A_START   = 6,
  parameter int F_MIN     = 2,
  parameter int A_MIN     = 2,
  parameter int STRESS_TH = 8,
  parameter int CALM_LVL  = 60,
  parameter int CALM_N    = 4
`ifdef WATCHDOG_EN
  ,
  parameter int WD_TICKS  = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       hartvld,
  input  logic [7:0] hartvol,
  output logic [3:0] freq,
  output logic [3:0] amp,
  output logic       busy,
  output logic       calm,
  output logic       fault,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    TRACK = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [3:0] FS = 4'(F_START);
  localparam logic [3:0] AS = 4'(A_START);
  localparam logic [3:0] FM = 4'(F_MIN);
  localparam logic [3:0] AM = 4'(A_MIN);
  localparam logic [8:0] ST = 9'(STRESS_TH);
  localparam logic [7:0] CL = 8'(CALM_LVL);
  localparam logic [3:0] CN = 4'(CALM_N);

  state_t     state, state_n;
  logic [3:0] freq_n, amp_n, calmcnt, calmcnt_n;
  logic [7:0] prev, prev_n;
  logic       first, first_n;

`ifdef WATCHDOG_EN
  localparam int WdW = $clog2(WD_TICKS + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WD_TICKS - 1);
  logic [WdW-1:0] wdcnt, wdcnt_n;
  logic           fault_n;
`endif

  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    freq_n    = freq;
    amp_n     = amp;
    calmcnt_n = calmcnt;
    prev_n    = prev;
    first_n   = first;
`ifdef WATCHDOG_EN
    wdcnt_n   = wdcnt;
    fault_n   = fault;
`endif
    case (state)
      IDLE: begin
        freq_n = 4'd0;
        amp_n  = 4'd0;
`ifdef WATCHDOG_EN
        // A latched fault holds the stage idle until enable is released.
        if (!enable)     fault_n = 1'b0;
        else if (!fault) state_n = START;
`else
        if (enable) state_n = START;
`endif
      end
      START: begin
        if (!enable) begin
          state_n = STOP;
        end else begin
          if (tick) begin
            if (freq < FS) freq_n = freq + 4'd1;
            if (amp < AS)  amp_n  = amp + 4'd1;
          end
          if (freq_n == FS && amp_n == AS) begin
            state_n   = TRACK;
            first_n   = 1'b1;
            calmcnt_n = 4'd0;
`ifdef WATCHDOG_EN
            wdcnt_n   = '0;
`endif
          end
        end
      end
      TRACK: begin
        if (!enable) begin
          state_n = STOP;
        end else if (hartvld) begin
`ifdef WATCHDOG_EN
          wdcnt_n = '0;
`endif
          prev_n = hartvol;
          if (first) begin
            first_n = 1'b0;
          end else if ({1'b0, hartvol} > ({1'b0, prev} + ST)) begin
            freq_n    = (freq == 4'd15) ? freq : freq + 4'd1;
            amp_n     = (amp == 4'd15) ? amp : amp + 4'd1;
            calmcnt_n = 4'd0;
          end else if (hartvol < CL) begin
            if (calmcnt + 4'd1 == CN) begin
              freq_n    = (freq > FM) ? freq - 4'd1 : freq;
              amp_n     = (amp > AM) ? amp - 4'd1 : amp;
              calmcnt_n = 4'd0;
            end else begin
              calmcnt_n = calmcnt + 4'd1;
            end
          end else begin
            calmcnt_n = 4'd0;
          end
`ifdef WATCHDOG_EN
        end else if (tick) begin
          if (wdcnt == WdLast) begin
            fault_n = 1'b1;
            state_n = STOP;
          end else begin
            wdcnt_n = wdcnt + 1'b1;
          end
`endif
        end
      end
      STOP: begin
        // Ramp always completes to IDLE; enable is only looked at again there.
        if (tick) begin
          if (freq != 4'd0) freq_n = freq - 4'd1;
          if (amp != 4'd0)  amp_n  = amp - 4'd1;
        end
        if (freq_n == 4'd0 && amp_n == 4'd0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      freq    <= 4'd0;
      amp     <= 4'd0;
      calmcnt <= 4'd0;
      prev    <= 8'd0;
      first   <= 1'b1;
      busy    <= 1'b0;
      calm    <= 1'b0;
    end else begin
      state   <= state_n;
      freq    <= freq_n;
      amp     <= amp_n;
      calmcnt <= calmcnt_n;
      prev    <= prev_n;
      first   <= first_n;
      busy    <= (state_n != IDLE);
      calm    <= (state_n == TRACK) && (freq_n == FM) && (amp_n == AM);
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdcnt <= '0;
      fault <= 1'b0;
    end else begin
      wdcnt <= wdcnt_n;
      fault <= fault_n;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule
